// File: rtl/game_pkg.sv
// Shared types, default key codes and BCD helper for the survival game controller.
package game_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_PAUSE = 2'd2,
    S_OVER  = 2'd3
  } game_state_t;

  localparam int          TICK_DIV_DEF   = 50_000_000;
  localparam int          LEVEL_SECS_DEF = 10;
  localparam int          OVER_HOLD_DEF  = 2;
  localparam logic [7:0]  START_KEY_DEF  = 8'h2C;
  localparam logic [7:0]  PAUSE_KEY_DEF  = 8'h13;
  localparam logic [23:0] BCD_MAX        = 24'h999999;

  // Six-digit BCD increment that sticks at 999999 instead of wrapping.
  function automatic logic [23:0] bcd_inc6(input logic [23:0] v);
    logic [23:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != BCD_MAX) begin
      for (int i = 0; i < 6; i++) begin
        if (carry) begin
          if (v[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Bundle between the game controller and the keyboard/ball/display side.
interface game_sequencer_if;

  logic [7:0]  keycode;
  logic        collide;
  logic        run;
  logic        obj_reset;
  logic        tick;
  logic [23:0] score;
  logic [23:0] best;
  logic [3:0]  level;
  logic [1:0]  state;

  modport master (
    input  keycode, collide,
    output run, obj_reset, tick, score, best, level, state
  );

  modport slave (
    output keycode, collide,
    input  run, obj_reset, tick, score, best, level, state
  );

endinterface

// File: rtl/bcd_counter6.sv
// Six-digit BCD counter with clear, load and saturating increment.
module bcd_counter6
  import game_pkg::*;
(
  input  logic        MAX10_CLK1_50,
  input  logic        Reset_h,
  input  logic        clr,
  input  logic        inc,
  input  logic        load,
  input  logic [23:0] load_val,
  output logic [23:0] count,
  output logic        is_max
);

  // Clear wins over load, load wins over increment.
  always_ff @(posedge MAX10_CLK1_50 or posedge Reset_h) begin
    if (Reset_h) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= bcd_inc6(count);
    end
  end

  assign is_max = (count == BCD_MAX);

endmodule

// File: rtl/game_sequencer.sv
// Game controller: 1 s tick, IDLE/PLAY/PAUSE/OVER flow, BCD score, best score, level.
module game_sequencer
  import game_pkg::*;
#(
  parameter int         TICK_DIV   = TICK_DIV_DEF,
  parameter int         LEVEL_SECS = LEVEL_SECS_DEF,
  parameter int         OVER_HOLD  = OVER_HOLD_DEF,
  parameter logic [7:0] START_KEY  = START_KEY_DEF,
  parameter logic [7:0] PAUSE_KEY  = PAUSE_KEY_DEF
) (
  input  logic             MAX10_CLK1_50,
  input  logic             Reset_h,
  game_sequencer_if.master gs
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (LEVEL_SECS > 1) ? $clog2(LEVEL_SECS) : 1;
  localparam int HW = (OVER_HOLD > 0) ? $clog2(OVER_HOLD + 1) : 1;

  localparam logic [PW-1:0] PRESC_LAST  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SEC_LAST    = SW'(LEVEL_SECS - 1);
  localparam logic [HW-1:0] HOLD_TARGET = HW'(OVER_HOLD);

  game_state_t   state, next_state;
  logic [7:0]    key_s1, key_s2, key_s3;
  logic          col_s1, col_s2;
  logic          start_press, pause_press;
  logic [PW-1:0] presc;
  logic [SW-1:0] sec_cnt;
  logic [HW-1:0] hold_cnt;
  logic          presc_wrap, hold_done, play_tick;
  logic          tick_q;
  logic [3:0]    level_q;
  logic [23:0]   score_q, best_q;
  logic          score_max;
  logic          run_c, obj_reset_c;

  // keycode and collide come from other clock domains; key_s3 remembers the
  // previous synchronized code so a held key counts as a single press.
  always_ff @(posedge MAX10_CLK1_50 or posedge Reset_h) begin
    if (Reset_h) begin
      key_s1 <= '0;
      key_s2 <= '0;
      key_s3 <= '0;
      col_s1 <= 1'b0;
      col_s2 <= 1'b0;
    end else begin
      key_s1 <= gs.keycode;
      key_s2 <= key_s1;
      key_s3 <= key_s2;
      col_s1 <= gs.collide;
      col_s2 <= col_s1;
    end
  end

  assign start_press = (key_s2 == START_KEY) && (key_s3 != START_KEY);
  assign pause_press = (key_s2 == PAUSE_KEY) && (key_s3 != PAUSE_KEY);
  assign presc_wrap  = (presc == PRESC_LAST);
  assign hold_done   = (hold_cnt == HOLD_TARGET);
  assign play_tick   = (state == S_PLAY) && !col_s2 && presc_wrap;

  always_ff @(posedge MAX10_CLK1_50 or posedge Reset_h) begin
    if (Reset_h) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Collision takes priority over a pause request arriving on the same cycle.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:  if (start_press) next_state = S_PLAY;
      S_PLAY: begin
        if (col_s2)           next_state = S_OVER;
        else if (pause_press) next_state = S_PAUSE;
      end
      S_PAUSE: if (pause_press) next_state = S_PLAY;
      S_OVER:  if (start_press && hold_done) next_state = S_IDLE;
    endcase
  end

  always_comb begin
    run_c       = 1'b0;
    obj_reset_c = 1'b0;
    unique case (state)
      S_IDLE:  obj_reset_c = 1'b1;
      S_PLAY:  run_c       = 1'b1;
      S_PAUSE: run_c       = 1'b0;
      S_OVER:  run_c       = 1'b0;
    endcase
  end

  // The prescaler is shared: survival seconds in PLAY, restart hold time in OVER.
  always_ff @(posedge MAX10_CLK1_50 or posedge Reset_h) begin
    if (Reset_h) begin
      presc    <= '0;
      hold_cnt <= '0;
    end else if (next_state == S_IDLE ||
                 (state == S_PLAY && next_state == S_OVER)) begin
      presc    <= '0;
      hold_cnt <= '0;
    end else if (state == S_PLAY || state == S_OVER) begin
      presc <= presc_wrap ? '0 : presc + PW'(1);
      if (state == S_OVER && presc_wrap && !hold_done) begin
        hold_cnt <= hold_cnt + HW'(1);
      end
    end
  end

  always_ff @(posedge MAX10_CLK1_50 or posedge Reset_h) begin
    if (Reset_h) begin
      tick_q  <= 1'b0;
      sec_cnt <= '0;
      level_q <= '0;
    end else begin
      tick_q <= play_tick;
      if (next_state == S_IDLE) begin
        sec_cnt <= '0;
        level_q <= '0;
      end else if (play_tick) begin
        if (sec_cnt == SEC_LAST) begin
          sec_cnt <= '0;
          if (level_q != 4'd15) level_q <= level_q + 4'd1;
        end else begin
          sec_cnt <= sec_cnt + SW'(1);
        end
      end
    end
  end

  bcd_counter6 u_score (
    .MAX10_CLK1_50 (MAX10_CLK1_50),
    .Reset_h       (Reset_h),
    .clr           (next_state == S_IDLE),
    .inc           (play_tick && !score_max),
    .load          (1'b0),
    .load_val      (24'h000000),
    .count         (score_q),
    .is_max        (score_max)
  );

  // Score is frozen in OVER, so a plain compare every cycle there lands one edge after entry.
  always_ff @(posedge MAX10_CLK1_50 or posedge Reset_h) begin
    if (Reset_h) begin
      best_q <= '0;
    end else if (state == S_OVER && score_q > best_q) begin
      best_q <= score_q;
    end
  end

  assign gs.run       = run_c;
  assign gs.obj_reset = obj_reset_c;
  assign gs.tick      = tick_q;
  assign gs.score     = score_q;
  assign gs.best      = best_q;
  assign gs.level     = level_q;
  assign gs.state     = state;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed scenarios plus random key/collide traffic against a scoreboard.
module tb_game_sequencer;

  localparam int         TDIV  = 10;
  localparam int         LSECS = 3;
  localparam int         OHOLD = 2;
  localparam logic [7:0] KSTART = 8'h2C;
  localparam logic [7:0] KPAUSE = 8'h13;

  typedef struct packed {
    logic [1:0]  st;
    logic        tk;
    logic [23:0] sc;
    logic [3:0]  lv;
    logic [23:0] bs;
    logic        rn;
    logic        orr;
  } obs_t;

  localparam obs_t RESET_OBS = '{st: 2'd0, tk: 1'b0, sc: 24'h0, lv: 4'd0,
                                 bs: 24'h0, rn: 1'b0, orr: 1'b1};

  logic clk = 1'b0;
  logic Reset_h;
  always #5 clk = ~clk;

  game_sequencer_if sif ();

  game_sequencer #(
    .TICK_DIV   (TDIV),
    .LEVEL_SECS (LSECS),
    .OVER_HOLD  (OHOLD),
    .START_KEY  (KSTART),
    .PAUSE_KEY  (KPAUSE)
  ) dut (
    .MAX10_CLK1_50 (clk),
    .Reset_h       (Reset_h),
    .gs            (sif)
  );

  logic        sat_clr, sat_inc, sat_load, sat_max;
  logic [23:0] sat_val, sat_count;

  bcd_counter6 u_sat (
    .MAX10_CLK1_50 (clk),
    .Reset_h       (Reset_h),
    .clr           (sat_clr),
    .inc           (sat_inc),
    .load          (sat_load),
    .load_val      (sat_val),
    .count         (sat_count),
    .is_max        (sat_max)
  );

  int   tests  = 0;
  int   failed = 0;
  bit   done   = 1'b0;
  obs_t exp_q[$];

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int          x;
    r = '0;
    x = v;
    for (int i = 0; i < 6; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic obs_t make_obs(input int st, input bit tk, input int ticks, input int bst);
    obs_t o;
    int   sc, lv;
    sc = (ticks > 999999) ? 999999 : ticks;
    lv = ticks / LSECS;
    if (lv > 15) lv = 15;
    o.st  = 2'(st);
    o.tk  = tk;
    o.sc  = to_bcd(sc);
    o.lv  = 4'(lv);
    o.bs  = to_bcd(bst);
    o.rn  = (st == 1);
    o.orr = (st == 0);
    return o;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] key, input logic col, input int cycles);
    @(negedge clk);
    sif.keycode = key;
    sif.collide = col;
    repeat (cycles) @(negedge clk);
    sif.keycode = 8'h00;
    sif.collide = 1'b0;
  endtask

  // Reference model: inputs become visible two cycles late; time is counted in
  // whole survival seconds and the displayed values are derived from that count.
  int         m_state, m_presc, m_ticks, m_hold, m_best;
  logic [7:0] kh0, kh1, kprev;
  logic       ch0, ch1;
  obs_t       prev_exp;

  initial begin
    obs_t       o;
    logic [7:0] seen;
    logic       col_seen;
    bit         ps, pp, tk, start_ok;
    int         cur, sc;
    forever begin
      @(posedge clk);
      if (Reset_h) begin
        m_state = 0; m_presc = 0; m_ticks = 0; m_hold = 0; m_best = 0;
        kh0 = '0; kh1 = '0; kprev = '0; ch0 = 1'b0; ch1 = 1'b0;
        exp_q.delete();
        prev_exp = RESET_OBS;
      end else begin
        seen     = kh1;
        col_seen = ch1;
        ps       = (seen == KSTART) && (kprev != KSTART);
        pp       = (seen == KPAUSE) && (kprev != KPAUSE);
        kprev    = seen;
        kh1      = kh0;
        kh0      = sif.keycode;
        ch1      = ch0;
        ch0      = sif.collide;
        tk       = 1'b0;
        cur      = m_state;
        sc       = (m_ticks > 999999) ? 999999 : m_ticks;
        if (cur == 3 && sc > m_best) m_best = sc;
        case (cur)
          0: if (ps) m_state = 1;
          1: begin
            if (col_seen) begin
              m_state = 3; m_presc = 0; m_hold = 0;
            end else begin
              m_presc++;
              if (m_presc == TDIV) begin
                m_presc = 0; m_ticks++; tk = 1'b1;
              end
              if (pp) m_state = 2;
            end
          end
          2: if (pp) m_state = 1;
          default: begin
            start_ok = (m_hold >= OHOLD);
            m_presc++;
            if (m_presc == TDIV) begin
              m_presc = 0;
              if (m_hold < OHOLD) m_hold++;
            end
            if (ps && start_ok) begin
              m_state = 0; m_ticks = 0; m_presc = 0; m_hold = 0;
            end
          end
        endcase
        o = make_obs(m_state, tk, m_ticks, m_best);
        if (o != prev_exp || tk) exp_q.push_back(o);
        prev_exp = o;
      end
    end
  end

  // Monitor: every visible output change or tick pulse consumes one expectation.
  initial begin
    obs_t prev, cur, e;
    prev = RESET_OBS;
    while (!done) begin
      @(posedge clk);
      #1;
      if (Reset_h) begin
        prev = RESET_OBS;
      end else begin
        cur = '{st: sif.state, tk: sif.tick, sc: sif.score, lv: sif.level,
                bs: sif.best, rn: sif.run, orr: sif.obj_reset};
        if (cur != prev || cur.tk) begin
          tests++;
          if (exp_q.size() == 0) begin
            failed++;
            $display("[TB] FAIL unexpected_event: got %h expected none", cur);
          end else begin
            e = exp_q.pop_front();
            if (cur !== e) begin
              failed++;
              $display("[TB] FAIL event @%0t: got st=%0d tk=%0b sc=%h lv=%0d bs=%h rn=%0b or=%0b expected st=%0d tk=%0b sc=%h lv=%0d bs=%h rn=%0b or=%0b",
                       $time, cur.st, cur.tk, cur.sc, cur.lv, cur.bs, cur.rn, cur.orr,
                       e.st, e.tk, e.sc, e.lv, e.bs, e.rn, e.orr);
            end
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    int r, cnt;
    Reset_h     = 1'b1;
    sif.keycode = 8'h00;
    sif.collide = 1'b0;
    sat_clr = 1'b0; sat_inc = 1'b0; sat_load = 1'b0; sat_val = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_state", 32'(sif.state), 0);
    checkOutput("rst_run", 32'(sif.run), 0);
    checkOutput("rst_obj_reset", 32'(sif.obj_reset), 1);
    checkOutput("rst_tick", 32'(sif.tick), 0);
    checkOutput("rst_score", 32'(sif.score), 0);
    checkOutput("rst_best", 32'(sif.best), 0);
    checkOutput("rst_level", 32'(sif.level), 0);
    @(negedge clk);
    Reset_h = 1'b0;
    repeat (2) @(negedge clk);

    // START press: PLAY three edges later, first tick TDIV cycles after that.
    sif.keycode = KSTART;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("start_not_early", 32'(sif.state), 0);
    @(posedge clk);
    #1;
    checkOutput("start_state", 32'(sif.state), 1);
    checkOutput("start_run", 32'(sif.run), 1);
    checkOutput("start_obj_reset", 32'(sif.obj_reset), 0);
    cnt = 0;
    do begin @(posedge clk); #1; cnt++; end while (!sif.tick && cnt < 30);
    checkOutput("first_tick_delay", 32'(cnt), 10);
    checkOutput("first_tick_score", 32'(sif.score), 32'h000001);

    // Held START across 35 seconds of play.
    repeat (340) @(posedge clk);
    #1;
    checkOutput("score_35", 32'(sif.score), 32'h000035);
    checkOutput("level_11", 32'(sif.level), 11);
    checkOutput("held_start_state", 32'(sif.state), 1);

    // Pause with the prescaler at 4, then resume.
    @(negedge clk);
    @(negedge clk);
    sif.keycode = KPAUSE;
    @(negedge clk);
    sif.keycode = 8'h00;
    repeat (50) @(posedge clk);
    #1;
    checkOutput("pause_state", 32'(sif.state), 2);
    checkOutput("pause_score", 32'(sif.score), 32'h000035);
    @(negedge clk);
    sif.keycode = KPAUSE;
    cnt = 0;
    do begin @(posedge clk); #1; cnt++; end while (sif.state != 2'd1 && cnt < 10);
    checkOutput("resume_latency", 32'(cnt), 3);
    cnt = 0;
    do begin @(posedge clk); #1; cnt++; end while (!sif.tick && cnt < 30);
    checkOutput("resume_tick_delay", 32'(cnt), 6);
    checkOutput("resume_score", 32'(sif.score), 32'h000036);

    // Collision lands exactly on the next tick edge.
    @(negedge clk);
    sif.keycode = 8'h00;
    repeat (7) @(negedge clk);
    sif.collide = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("over_state", 32'(sif.state), 3);
    checkOutput("over_tick_dropped", 32'(sif.tick), 0);
    checkOutput("over_score", 32'(sif.score), 32'h000036);
    @(posedge clk);
    #1;
    checkOutput("over_best", 32'(sif.best), 32'h000036);
    @(negedge clk);
    sif.collide = 1'b0;
    sif.keycode = KSTART;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("early_start_ignored", 32'(sif.state), 3);
    @(negedge clk);
    sif.keycode = 8'h00;
    repeat (20) @(negedge clk);
    sif.keycode = KSTART;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("restart_state", 32'(sif.state), 0);
    checkOutput("restart_score", 32'(sif.score), 0);
    checkOutput("restart_best", 32'(sif.best), 32'h000036);
    @(negedge clk);
    sif.keycode = 8'h00;

    // Score counter saturation and carry, checked on a standalone instance.
    sat_load = 1'b1; sat_val = 24'h999998;
    @(negedge clk);
    sat_load = 1'b0;
    checkOutput("sat_load", 32'(sat_count), 32'h999998);
    checkOutput("sat_not_max", 32'(sat_max), 0);
    sat_inc = 1'b1;
    repeat (3) @(negedge clk);
    sat_inc = 1'b0;
    checkOutput("sat_hold", 32'(sat_count), 32'h999999);
    checkOutput("sat_max", 32'(sat_max), 1);
    sat_load = 1'b1; sat_val = 24'h019999;
    @(negedge clk);
    sat_load = 1'b0; sat_inc = 1'b1;
    @(negedge clk);
    sat_inc = 1'b0;
    checkOutput("bcd_carry", 32'(sat_count), 32'h020000);
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    checkOutput("sat_clr", 32'(sat_count), 0);

    // Random key and collision traffic, judged by the scoreboard.
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 2) begin
        applyStimulus(KSTART, 1'b0, $urandom_range(1, 4));
      end else if (r <= 4) begin
        applyStimulus(KPAUSE, 1'b0, $urandom_range(1, 4));
      end else if (r == 5) begin
        logic [7:0] k;
        k = 8'($urandom_range(0, 255));
        if (k == KSTART || k == KPAUSE) k = 8'h04;
        applyStimulus(k, 1'b0, $urandom_range(1, 3));
      end else if (r == 6) begin
        applyStimulus(8'h00, 1'b1, $urandom_range(1, 3));
      end else begin
        repeat ($urandom_range(1, 40)) @(negedge clk);
      end
    end
    repeat (5) @(posedge clk);
    #1;
    checkOutput("scoreboard_drain", 32'(exp_q.size()), 0);

    // Reach OVER with best=000012, then reset mid-game.
    @(negedge clk);
    Reset_h = 1'b1;
    @(negedge clk);
    Reset_h = 1'b0;
    applyStimulus(KSTART, 1'b0, 1);
    cnt = 0;
    do begin @(posedge clk); #1; cnt++; end while (sif.score != 24'h000012 && cnt < 300);
    checkOutput("reach_12", 32'(sif.score), 32'h000012);
    @(negedge clk);
    sif.collide = 1'b1;
    @(negedge clk);
    sif.collide = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("over12_state", 32'(sif.state), 3);
    checkOutput("over12_best", 32'(sif.best), 32'h000012);
    @(negedge clk);
    Reset_h = 1'b1;
    #1;
    checkOutput("midrst_state", 32'(sif.state), 0);
    checkOutput("midrst_run", 32'(sif.run), 0);
    checkOutput("midrst_obj_reset", 32'(sif.obj_reset), 1);
    checkOutput("midrst_tick", 32'(sif.tick), 0);
    checkOutput("midrst_score", 32'(sif.score), 0);
    checkOutput("midrst_best", 32'(sif.best), 0);
    checkOutput("midrst_level", 32'(sif.level), 0);
    @(negedge clk);
    Reset_h = 1'b0;
    repeat (3) @(posedge clk);
    done = 1'b1;
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
